risc_v_mike_wb_stage: RTL and testbench

//  Writeback stage: sits directly upstream of the register file and owns its single write port.

---
 rtl/risc_v_mike_pkg.sv | 37 +++
 rtl/risc_v_mike_load_align.sv | 49 ++++
 rtl/risc_v_mike_wb_stage.sv | 180 ++++++++++++++++++
 tb/tb_risc_v_mike_wb_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_mike_pkg.sv
// risc_v_mike_pkg
//   Shared types for the risc_v_mike writeback path: register address type,
//   writeback source select, load-size (funct3) codes and the MEM/WB entry
//   struct buffered by the writeback FIFO.
package risc_v_mike_pkg;

    localparam int DATA_32_W = 32;

    typedef logic [4:0] t_register_addr;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } t_wb_sel;

    // Encodings are the RV32I load funct3 values.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } t_load_size;

    typedef struct packed {
        logic                 reg_write;
        t_register_addr       rd_addr;
        t_wb_sel              sel;
        logic [DATA_32_W-1:0] alu_result;
        logic [DATA_32_W-1:0] pc_plus4;
        logic [DATA_32_W-1:0] load_data;
        t_load_size           load_size;
        logic [1:0]           byte_off;
    } t_wb_entry;

endpackage

// File: rtl/risc_v_mike_load_align.sv
// risc_v_mike_load_align
//   Combinational load alignment: shifts the raw memory word down by the
//   byte offset, then sign- or zero-extends a byte/halfword, and flags
//   accesses that straddle the word boundary.
// Ports
//   load_data  in   32  raw aligned memory word
//   load_size  in   t_load_size  LB/LH/LW/LBU/LHU
//   byte_off   in   2   address[1:0] of the load
//   load_value out  32  aligned, extended result
//   misalign   out  1   LH/LHU at offset 3, or LW at a non-zero offset
module risc_v_mike_load_align
    import risc_v_mike_pkg::*;
(
    input  logic [DATA_32_W-1:0] load_data,
    input  t_load_size           load_size,
    input  logic [1:0]           byte_off,
    output logic [DATA_32_W-1:0] load_value,
    output logic                 misalign
);

    logic [DATA_32_W-1:0] shifted;

    assign shifted = load_data >> {byte_off, 3'b000};

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        load_value = shifted;
        misalign   = 1'b0;
        case (load_size)
            LB:  load_value = {{24{shifted[7]}}, shifted[7:0]};
            LBU: load_value = {24'h0, shifted[7:0]};
            LH: begin
                load_value = {{16{shifted[15]}}, shifted[15:0]};
                misalign   = (byte_off == 2'd3);
            end
            LHU: begin
                load_value = {16'h0, shifted[15:0]};
                misalign   = (byte_off == 2'd3);
            end
            LW: begin
                load_value = load_data;
                misalign   = (byte_off != 2'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/risc_v_mike_wb_stage.sv
// risc_v_mike_wb_stage
//   Writeback stage owning the register file write port. Retiring results
//   from MEM are accepted over valid/ready into a small FIFO, one entry per
//   cycle is popped, its writeback data selected/aligned, and the result is
//   registered onto the register-file write port.
// Ports
//   clk, rst (async, active-low)
//   mem_wb_valid / mem_wb_ready        MEM handshake (ready registered, = !full)
//   mem_wb_*                           entry fields (reg_write, rd, sel, data, load info)
//   wb_stall                           hold: no pop this cycle
//   wb_flush                           empty FIFO, kill the output write
//   reg_file_write/wr_addr/wr_data     register file write port (registered)
//   wb_retire                          1-cycle pulse per retired entry
//   wb_misalign_err                    1-cycle pulse per dropped misaligned load
//   wb_fwd_valid/addr/data             forwarding copy of the write port
// Configuration
//   MIKE_WB_FWD_EN  defined: wb_fwd_* mirror the write port; undefined: tied to 0.
module risc_v_mike_wb_stage
    import risc_v_mike_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wb_valid,
    output logic              mem_wb_ready,
    input  logic              mem_wb_reg_write,
    input  t_register_addr    mem_wb_rd_addr,
    input  t_wb_sel           mem_wb_sel,
    input  logic [DATA_W-1:0] mem_wb_alu_result,
    input  logic [DATA_W-1:0] mem_wb_pc_plus4,
    input  logic [DATA_W-1:0] mem_wb_load_data,
    input  t_load_size        mem_wb_load_size,
    input  logic [1:0]        mem_wb_byte_off,
    input  logic              wb_stall,
    input  logic              wb_flush,
    output logic              reg_file_write,
    output t_register_addr    reg_file_wr_addr,
    output logic [DATA_W-1:0] reg_file_wr_data,
    output logic              wb_retire,
    output logic              wb_misalign_err,
    output logic              wb_fwd_valid,
    output t_register_addr    wb_fwd_addr,
    output logic [DATA_W-1:0] wb_fwd_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    t_wb_entry            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count, count_next;
    logic                 ready_q;
    logic                 push, pop;
    t_wb_entry            entry_in, head;

    logic [DATA_32_W-1:0] load_value;
    logic                 load_misalign;
    logic                 misalign_eff;
    logic [DATA_32_W-1:0] wb_data;

    logic                 wr_q, retire_q, err_q;
    t_register_addr       addr_q;
    logic [DATA_W-1:0]    data_q;

    assign entry_in = '{
        reg_write:  mem_wb_reg_write,
        rd_addr:    mem_wb_rd_addr,
        sel:        mem_wb_sel,
        alu_result: mem_wb_alu_result,
        pc_plus4:   mem_wb_pc_plus4,
        load_data:  mem_wb_load_data,
        load_size:  mem_wb_load_size,
        byte_off:   mem_wb_byte_off
    };

    // Flush dominates: an offered push during a flush is dropped too.
    assign push = mem_wb_valid && ready_q && !wb_flush;
    assign pop  = (count != '0) && !wb_stall && !wb_flush;
    assign head = fifo_mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (wb_flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (wb_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                // Power-of-2 depth: pointers wrap naturally.
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            ready_q <= (count_next != FULL_CNT);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the count qualifies every
    // read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= entry_in;
    end

    risc_v_mike_load_align u_load_align (
        .load_data  (head.load_data),
        .load_size  (head.load_size),
        .byte_off   (head.byte_off),
        .load_value (load_value),
        .misalign   (load_misalign)
    );

    assign misalign_eff = (head.sel == WB_LOAD) && load_misalign;

    always_comb begin
        wb_data = head.alu_result;
        case (head.sel)
            WB_LOAD: wb_data = load_value;
            WB_PC4:  wb_data = head.pc_plus4;
            default: wb_data = head.alu_result;
        endcase
    end

    // Write enable/pulses are valid only in the cycle after a pop; address and
    // data hold their last values otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q     <= 1'b0;
            retire_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (pop) begin
            wr_q     <= head.reg_write && (head.rd_addr != '0) && !misalign_eff;
            retire_q <= 1'b1;
            err_q    <= misalign_eff;
            addr_q   <= head.rd_addr;
            data_q   <= wb_data;
        end else begin
            wr_q     <= 1'b0;
            retire_q <= 1'b0;
            err_q    <= 1'b0;
        end
    end

    assign mem_wb_ready     = ready_q;
    assign reg_file_write   = wr_q;
    assign reg_file_wr_addr = addr_q;
    assign reg_file_wr_data = data_q;
    assign wb_retire        = retire_q;
    assign wb_misalign_err  = err_q;

`ifdef MIKE_WB_FWD_EN
    assign wb_fwd_valid = wr_q;
    assign wb_fwd_addr  = addr_q;
    assign wb_fwd_data  = data_q;
`else
    assign wb_fwd_valid = 1'b0;
    assign wb_fwd_addr  = '0;
    assign wb_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_risc_v_mike_wb_stage.sv
module tb_risc_v_mike_wb_stage;
    import risc_v_mike_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           mem_wb_valid;
    logic           mem_wb_ready;
    logic           mem_wb_reg_write;
    t_register_addr mem_wb_rd_addr;
    t_wb_sel        mem_wb_sel;
    logic [31:0]    mem_wb_alu_result;
    logic [31:0]    mem_wb_pc_plus4;
    logic [31:0]    mem_wb_load_data;
    t_load_size     mem_wb_load_size;
    logic [1:0]     mem_wb_byte_off;
    logic           wb_stall;
    logic           wb_flush;
    logic           reg_file_write;
    t_register_addr reg_file_wr_addr;
    logic [31:0]    reg_file_wr_data;
    logic           wb_retire;
    logic           wb_misalign_err;
    logic           wb_fwd_valid;
    t_register_addr wb_fwd_addr;
    logic [31:0]    wb_fwd_data;

    int checks = 0;
    int errors = 0;

    risc_v_mike_wb_stage #(.DATA_W(32), .FIFO_DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_ready      (mem_wb_ready),
        .mem_wb_reg_write  (mem_wb_reg_write),
        .mem_wb_rd_addr    (mem_wb_rd_addr),
        .mem_wb_sel        (mem_wb_sel),
        .mem_wb_alu_result (mem_wb_alu_result),
        .mem_wb_pc_plus4   (mem_wb_pc_plus4),
        .mem_wb_load_data  (mem_wb_load_data),
        .mem_wb_load_size  (mem_wb_load_size),
        .mem_wb_byte_off   (mem_wb_byte_off),
        .wb_stall          (wb_stall),
        .wb_flush          (wb_flush),
        .reg_file_write    (reg_file_write),
        .reg_file_wr_addr  (reg_file_wr_addr),
        .reg_file_wr_data  (reg_file_wr_data),
        .wb_retire         (wb_retire),
        .wb_misalign_err   (wb_misalign_err),
        .wb_fwd_valid      (wb_fwd_valid),
        .wb_fwd_addr       (wb_fwd_addr),
        .wb_fwd_data       (wb_fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input t_register_addr rd, input t_wb_sel s,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] ld, input t_load_size sz, input logic [1:0] off);
        mem_wb_valid      = 1'b1;
        mem_wb_reg_write  = rw;
        mem_wb_rd_addr    = rd;
        mem_wb_sel        = s;
        mem_wb_alu_result = alu;
        mem_wb_pc_plus4   = pc4;
        mem_wb_load_data  = ld;
        mem_wb_load_size  = sz;
        mem_wb_byte_off   = off;
    endtask

    task automatic check_port(input string tag, input logic w, input logic ret, input logic err);
        check({tag, "_write"},  {31'h0, reg_file_write},  {31'h0, w});
        check({tag, "_retire"}, {31'h0, wb_retire},       {31'h0, ret});
        check({tag, "_err"},    {31'h0, wb_misalign_err}, {31'h0, err});
    endtask

    task automatic check_wr(input string tag, input t_register_addr a, input logic [31:0] d);
        check({tag, "_addr"}, {27'h0, reg_file_wr_addr}, {27'h0, a});
        check({tag, "_data"}, reg_file_wr_data, d);
    endtask

    task automatic check_fwd(input string tag, input logic v, input t_register_addr a, input logic [31:0] d);
`ifdef MIKE_WB_FWD_EN
        check({tag, "_fwd_valid"}, {31'h0, wb_fwd_valid}, {31'h0, v});
        check({tag, "_fwd_addr"},  {27'h0, wb_fwd_addr},  {27'h0, a});
        check({tag, "_fwd_data"},  wb_fwd_data, d);
`else
        check({tag, "_fwd_valid"}, {31'h0, wb_fwd_valid}, 32'h0);
        check({tag, "_fwd_addr"},  {27'h0, wb_fwd_addr},  32'h0);
        check({tag, "_fwd_data"},  wb_fwd_data, {32{v & a[0] & d[0] & 1'b0}});
`endif
    endtask

    initial begin
        rst = 1'b0;
        mem_wb_valid = 1'b0;
        mem_wb_reg_write = 1'b0;
        mem_wb_rd_addr = '0;
        mem_wb_sel = WB_ALU;
        mem_wb_alu_result = '0;
        mem_wb_pc_plus4 = '0;
        mem_wb_load_data = '0;
        mem_wb_load_size = LW;
        mem_wb_byte_off = '0;
        wb_stall = 1'b0;
        wb_flush = 1'b0;

        // Reset state
        #12;
        check_port("rst", 1'b0, 1'b0, 1'b0);
        check_wr("rst", 5'd0, 32'h0);
        check_fwd("rst", 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rst_ready", {31'h0, mem_wb_ready}, 32'h1);

        // 1. ALU entry: no bypass, written one edge after the push
        drive(1'b1, 5'd5, WB_ALU, 32'h1234_5678, 32'h0, 32'h0, LW, 2'd0);
        step();
        mem_wb_valid = 1'b0;
        check_port("alu_k", 1'b0, 1'b0, 1'b0);
        step();
        check_port("alu_k1", 1'b1, 1'b1, 1'b0);
        check_wr("alu_k1", 5'd5, 32'h1234_5678);
        check_fwd("alu_k1", 1'b1, 5'd5, 32'h1234_5678);
        step();
        check_port("alu_k2", 1'b0, 1'b0, 1'b0);
        check_wr("alu_hold", 5'd5, 32'h1234_5678);
        check_fwd("alu_k2", 1'b0, 5'd5, 32'h1234_5678);

        // 2. Streamed loads (push+pop each cycle), alu_result is a decoy
        drive(1'b1, 5'd1, WB_LOAD, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, LB, 2'd3);
        step();
        drive(1'b1, 5'd2, WB_LOAD, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, LBU, 2'd3);
        step();
        check_port("lb", 1'b1, 1'b1, 1'b0);
        check_wr("lb", 5'd1, 32'hFFFF_FF80);
        drive(1'b1, 5'd3, WB_LOAD, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, LH, 2'd2);
        step();
        mem_wb_valid = 1'b0;
        check_wr("lbu", 5'd2, 32'h0000_0080);
        check("stream_ready", {31'h0, mem_wb_ready}, 32'h1);
        step();
        check_port("lh", 1'b1, 1'b1, 1'b0);
        check_wr("lh", 5'd3, 32'hFFFF_80FF);
        drive(1'b1, 5'd8, WB_LOAD, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, LHU, 2'd0);
        step();
        mem_wb_valid = 1'b0;
        check_port("stream_idle", 1'b0, 1'b0, 1'b0);
        step();
        check_wr("lhu", 5'd8, 32'h0000_7F01);

        // 3. Misaligned loads, x0, reg_write=0, PC+4
        drive(1'b1, 5'd4, WB_LOAD, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, LW, 2'd2);
        step();
        drive(1'b1, 5'd6, WB_LOAD, 32'hDEAD_BEEF, 32'h0, 32'h80FF_7F01, LH, 2'd3);
        step();
        check_port("lw_off2", 1'b0, 1'b1, 1'b1);
        drive(1'b1, 5'd0, WB_ALU, 32'h0000_AAAA, 32'h0, 32'h0, LW, 2'd0);
        step();
        check_port("lh_off3", 1'b0, 1'b1, 1'b1);
        drive(1'b0, 5'd7, WB_ALU, 32'h0000_BBBB, 32'h0, 32'h0, LW, 2'd0);
        step();
        check_port("rd0", 1'b0, 1'b1, 1'b0);
        drive(1'b1, 5'd1, WB_PC4, 32'h0000_0011, 32'h0000_0104, 32'h0, LW, 2'd0);
        step();
        mem_wb_valid = 1'b0;
        check_port("nowrite", 1'b0, 1'b1, 1'b0);
        step();
        check_port("pc4", 1'b1, 1'b1, 1'b0);
        check_wr("pc4", 5'd1, 32'h0000_0104);

        // 4. Stall held 4 cycles with 3 pushes offered
        wb_stall = 1'b1;
        drive(1'b1, 5'd10, WB_ALU, 32'hA000_000A, 32'h0, 32'h0, LW, 2'd0);
        step();
        check("stall_rdy1", {31'h0, mem_wb_ready}, 32'h1);
        check_port("stall_c1", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd11, WB_ALU, 32'hB000_000B, 32'h0, 32'h0, LW, 2'd0);
        step();
        check("stall_rdy2", {31'h0, mem_wb_ready}, 32'h0);
        drive(1'b1, 5'd12, WB_ALU, 32'hC000_000C, 32'h0, 32'h0, LW, 2'd0);
        step();
        check("stall_rdy3", {31'h0, mem_wb_ready}, 32'h0);
        check_port("stall_c3", 1'b0, 1'b0, 1'b0);
        step();
        check("stall_rdy4", {31'h0, mem_wb_ready}, 32'h0);
        mem_wb_valid = 1'b0;
        wb_stall = 1'b0;
        step();
        check_port("drain_a", 1'b1, 1'b1, 1'b0);
        check_wr("drain_a", 5'd10, 32'hA000_000A);
        check("drain_rdy", {31'h0, mem_wb_ready}, 32'h1);
        step();
        check_port("drain_b", 1'b1, 1'b1, 1'b0);
        check_wr("drain_b", 5'd11, 32'hB000_000B);
        step();
        check_port("drain_end", 1'b0, 1'b0, 1'b0);

        // 5. Flush with 2 entries queued
        wb_stall = 1'b1;
        drive(1'b1, 5'd13, WB_ALU, 32'h1313_1313, 32'h0, 32'h0, LW, 2'd0);
        step();
        drive(1'b1, 5'd14, WB_ALU, 32'h1414_1414, 32'h0, 32'h0, LW, 2'd0);
        step();
        mem_wb_valid = 1'b0;
        check("flush_full", {31'h0, mem_wb_ready}, 32'h0);
        wb_stall = 1'b0;
        wb_flush = 1'b1;
        step();
        check_port("flush_c1", 1'b0, 1'b0, 1'b0);
        check("flush_rdy", {31'h0, mem_wb_ready}, 32'h1);
        wb_flush = 1'b0;
        step();
        check_port("flush_c2", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 5'd15, WB_ALU, 32'h1515_1515, 32'h0, 32'h0, LW, 2'd0);
        step();
        mem_wb_valid = 1'b0;
        step();
        check_port("post_flush", 1'b1, 1'b1, 1'b0);
        check_wr("post_flush", 5'd15, 32'h1515_1515);

        // 6. Async reset mid-stream
        wb_stall = 1'b1;
        drive(1'b1, 5'd9, WB_ALU, 32'h9999_9999, 32'h0, 32'h0, LW, 2'd0);
        step();
        drive(1'b1, 5'd10, WB_ALU, 32'h1010_1010, 32'h0, 32'h0, LW, 2'd0);
        step();
        mem_wb_valid = 1'b0;
        wb_stall = 1'b0;
        step();
        check_port("pre_rst", 1'b1, 1'b1, 1'b0);
        check_wr("pre_rst", 5'd9, 32'h9999_9999);
        #2;
        rst = 1'b0;
        #1;
        check_port("async_rst", 1'b0, 1'b0, 1'b0);
        check_wr("async_rst", 5'd0, 32'h0);
        check_fwd("async_rst", 1'b0, 5'd0, 32'h0);
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rel_ready", {31'h0, mem_wb_ready}, 32'h1);
        check_port("rel_c1", 1'b0, 1'b0, 1'b0);
        step();
        check_port("rel_c2", 1'b0, 1'b0, 1'b0);
        check_wr("rel_c2", 5'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
